stencil_job_sequencer: RTL and testbench

//  Batch controller for one stencil_2d HLS component. Buffers job descriptors (orig/sol/filter

---
 rtl/stencil_seq_pkg.sv | 26 ++
 rtl/stencil_seq_fifo.sv | 60 ++++++
 rtl/stencil_job_sequencer.sv | 151 +++++++++++++++
 tb/tb_stencil_job_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stencil_seq_pkg.sv
// Shared types for the stencil_2d job sequencer: FSM states, result status codes, job descriptor.
package stencil_seq_pkg;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned TAG_MAX_W = 32;
  localparam int unsigned STATUS_W  = 2;

  localparam logic [STATUS_W-1:0] ST_OK      = 2'd0;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RETIRE = 2'd3
  } state_t;

  // Tag field is sized for the widest supported tag; narrower tags are zero-extended.
  typedef struct packed {
    logic [ADDR_W-1:0]    orig;
    logic [ADDR_W-1:0]    sol;
    logic [ADDR_W-1:0]    filter;
    logic [TAG_MAX_W-1:0] tag;
  } desc_t;

endpackage

// File: rtl/stencil_seq_fifo.sv
// Synchronous descriptor FIFO with registered not_full/empty flags.
module stencil_seq_fifo
  import stencil_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  desc_t push_data,
  input  logic  pop,
  output desc_t head,
  output logic  not_full,
  output logic  empty,
  output logic  empty_nxt_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  desc_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic           do_push;
  logic           do_pop;

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop      = pop && !empty;
    do_push     = push && (not_full || do_pop);
    count_nxt   = count + CW'(do_push) - CW'(do_pop);
    empty_nxt_c = (count_nxt == '0);
    head        = mem[rd_ptr];
  end

  // Descriptor storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b1;
      empty    <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      not_full <= (count_nxt != CW'(DEPTH));
      empty    <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/stencil_job_sequencer.sv
// Batch launcher for one stencil_2d component: buffers descriptors, runs one call at a time,
// and returns tagged results. Optional watchdog: define STENCIL_SEQ_TIMEOUT_EN.
module stencil_job_sequencer
  import stencil_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TAG_W          = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [63:0]         job_orig,
  input  logic [63:0]         job_sol,
  input  logic [63:0]         job_filter,
  input  logic [TAG_W-1:0]    job_tag,
  output logic                comp_start,
  input  logic                comp_busy,
  input  logic                comp_done,
  output logic                comp_stall,
  input  logic [31:0]         comp_returndata,
  output logic [63:0]         comp_orig,
  output logic [63:0]         comp_sol,
  output logic [63:0]         comp_filter,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [31:0]         res_data,
  output logic [TAG_W-1:0]    res_tag,
  output logic [1:0]          res_status,
  output logic                idle,
  output logic [CNT_W-1:0]    jobs_done
);

  localparam int unsigned TO_W = 32;

  state_t           state;
  desc_t            push_desc;
  desc_t            head;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_empty_nxt_c;
  logic [TAG_W-1:0] cur_tag;

  assign push_desc = '{orig: job_orig, sol: job_sol, filter: job_filter,
                       tag: TAG_MAX_W'(job_tag)};
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;

  stencil_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (job_valid && job_ready),
    .push_data   (push_desc),
    .pop         (fifo_pop),
    .head        (head),
    .not_full    (job_ready),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt_c)
  );

`ifdef STENCIL_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] run_cnt;
  logic [1:0]      status_q;
  assign res_status = status_q;
`else
  assign res_status = ST_OK;
`endif

  // Call sequencing: one outstanding call; stall is released only while waiting for done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      comp_start  <= 1'b0;
      comp_stall  <= 1'b1;
      comp_orig   <= '0;
      comp_sol    <= '0;
      comp_filter <= '0;
      cur_tag     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_tag     <= '0;
      idle        <= 1'b1;
      jobs_done   <= '0;
`ifdef STENCIL_SEQ_TIMEOUT_EN
      run_cnt     <= '0;
      status_q    <= ST_OK;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            comp_orig   <= head.orig;
            comp_sol    <= head.sol;
            comp_filter <= head.filter;
            cur_tag     <= TAG_W'(head.tag);
            comp_start  <= 1'b1;
            idle        <= 1'b0;
            state       <= S_LAUNCH;
          end else begin
            idle <= fifo_empty_nxt_c;
          end
        end
        S_LAUNCH: begin
          if (!comp_busy) begin
            comp_start <= 1'b0;
            comp_stall <= 1'b0;
`ifdef STENCIL_SEQ_TIMEOUT_EN
            run_cnt    <= '0;
`endif
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (comp_done) begin
            res_data   <= comp_returndata;
            res_tag    <= cur_tag;
            res_valid  <= 1'b1;
            comp_stall <= 1'b1;
`ifdef STENCIL_SEQ_TIMEOUT_EN
            status_q   <= ST_OK;
`endif
            state      <= S_RETIRE;
          end
`ifdef STENCIL_SEQ_TIMEOUT_EN
          else if (run_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            res_data   <= '0;
            res_tag    <= cur_tag;
            res_valid  <= 1'b1;
            comp_stall <= 1'b1;
            status_q   <= ST_TIMEOUT;
            state      <= S_RETIRE;
          end else begin
            run_cnt <= run_cnt + TO_W'(1);
          end
`endif
        end
        S_RETIRE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            jobs_done <= jobs_done + CNT_W'(1);
            idle      <= fifo_empty_nxt_c;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stencil_job_sequencer.sv
// Directed self-checking bench for stencil_job_sequencer.
module tb_stencil_job_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [63:0] job_orig = '0, job_sol = '0, job_filter = '0;
  logic [7:0]  job_tag = '0;
  logic        comp_start;
  logic        comp_busy = 1'b0;
  logic        comp_done = 1'b0;
  logic        comp_stall;
  logic [31:0] comp_returndata = '0;
  logic [63:0] comp_orig, comp_sol, comp_filter;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [7:0]  res_tag;
  logic [1:0]  res_status;
  logic        idle;
  logic [15:0] jobs_done;

  int checks   = 0;
  int failures = 0;
  int calls    = 0;

  stencil_job_sequencer #(
    .FIFO_DEPTH(4), .TAG_W(8), .CNT_W(16)
`ifdef STENCIL_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_orig(job_orig), .job_sol(job_sol), .job_filter(job_filter), .job_tag(job_tag),
    .comp_start(comp_start), .comp_busy(comp_busy), .comp_done(comp_done),
    .comp_stall(comp_stall), .comp_returndata(comp_returndata),
    .comp_orig(comp_orig), .comp_sol(comp_sol), .comp_filter(comp_filter),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_status(res_status),
    .idle(idle), .jobs_done(jobs_done)
  );

  always #5 clock = ~clock;

  // Count accepted calls on the component interface.
  always @(posedge clock) begin
    if (!reset && comp_start && !comp_busy) calls <= calls + 1;
  end

  // Hard stop if something hangs.
  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [63:0] orig;
    logic [63:0] sol;
    logic [63:0] filter;
    logic [7:0]  tag;
    logic [31:0] ret;
    logic [31:0] exp_data;
    logic [15:0] exp_done;
  } vec_t;

  vec_t vecs [3];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_job(input logic [63:0] o, input logic [63:0] s, input logic [63:0] f,
                          input logic [7:0] t);
    job_valid = 1'b1; job_orig = o; job_sol = s; job_filter = f; job_tag = t;
    step();
    job_valid = 1'b0;
  endtask

  // From IDLE with a buffered job: launch (busy=0), return one cycle after start, reach RETIRE.
  task automatic to_retire(input logic [31:0] ret, input logic [7:0] t, input logic [63:0] o);
    step();
    chk("launch_start", comp_start, 1);
    chk("launch_orig", comp_orig, o);
    step();
    chk("run_start_drop", comp_start, 0);
    chk("run_stall_low", comp_stall, 0);
    comp_done = 1'b1; comp_returndata = ret;
    step();
    comp_done = 1'b0;
    chk("retire_valid", res_valid, 1);
    chk("retire_data", res_data, ret);
    chk("retire_tag", res_tag, t);
    chk("retire_status", res_status, 0);
    chk("retire_stall", comp_stall, 1);
  endtask

  task automatic retire(input logic [15:0] exp_done);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("retired_valid_low", res_valid, 0);
    chk("jobs_done", jobs_done, exp_done);
  endtask

  initial begin
    vecs[0] = '{orig: 64'h1000, sol: 64'h2000, filter: 64'h3000, tag: 8'd5,
                ret: 32'h2A, exp_data: 32'h0000_002A, exp_done: 16'd1};
    vecs[1] = '{orig: 64'hFFFF_FFFF_FFFF_FFF0, sol: 64'h8000_0000_0000_0000, filter: 64'h1,
                tag: 8'hFF, ret: 32'hFFFF_FFFF, exp_data: 32'hFFFF_FFFF, exp_done: 16'd2};
    vecs[2] = '{orig: 64'h0, sol: 64'hDEAD_BEEF, filter: 64'hCAFE_0000, tag: 8'h00,
                ret: 32'h0, exp_data: 32'h0, exp_done: 16'd3};

    // Reset state
    step(); step();
    chk("rst_start", comp_start, 0);
    chk("rst_stall", comp_stall, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_orig", comp_orig, 0);
    reset = 1'b0;
    step();
    chk("rst_idle", idle, 1);
    chk("rst_job_ready", job_ready, 1);

    // Single jobs, 4-cycle push-to-result latency
    for (int i = 0; i < 3; i++) begin
      push_job(vecs[i].orig, vecs[i].sol, vecs[i].filter, vecs[i].tag);
      step();
      chk("vec_launch", comp_start, 1);
      chk("vec_orig", comp_orig, vecs[i].orig);
      chk("vec_sol", comp_sol, vecs[i].sol);
      chk("vec_filter", comp_filter, vecs[i].filter);
      step();
      chk("vec_run_stall", comp_stall, 0);
      comp_done = 1'b1; comp_returndata = vecs[i].ret;
      step();
      comp_done = 1'b0;
      chk("vec_res_valid", res_valid, 1);
      chk("vec_res_data", res_data, vecs[i].exp_data);
      chk("vec_res_tag", res_tag, vecs[i].tag);
      chk("vec_res_status", res_status, 0);
      retire(vecs[i].exp_done);
      chk("vec_idle", idle, 1);
    end

    // Busy held for 10 cycles in LAUNCH: start held, args stable, one call accepted
    begin
      int calls0;
      calls0 = calls;
      comp_busy = 1'b1;
      push_job(64'h5000, 64'h6000, 64'h7000, 8'h33);
      step();
      for (int i = 0; i < 10; i++) begin
        chk("busy_start_held", comp_start, 1);
        chk("busy_orig_stable", comp_orig, 64'h5000);
        chk("busy_filter_stable", comp_filter, 64'h7000);
        step();
      end
      comp_busy = 1'b0;
      step();
      chk("busy_start_drop", comp_start, 0);
      step();
      chk("busy_one_call", 64'(calls - calls0), 1);
      comp_done = 1'b1; comp_returndata = 32'h77;
      step();
      comp_done = 1'b0;
      chk("busy_res_data", res_data, 32'h77);
      chk("busy_res_tag", res_tag, 8'h33);
      retire(16'd4);
    end

    // Five jobs into a depth-4 buffer, results drained in tag order
    begin
      int got;
      comp_busy = 1'b1;
      for (int k = 0; k < 5; k++) begin
        chk("fill_ready", job_ready, 1);
        job_valid = 1'b1; job_tag = 8'(10 + k); job_orig = 64'(k);
        step();
      end
      chk("fill_full", job_ready, 0);
      job_tag = 8'd99;
      step(); step();
      job_valid = 1'b0;
      comp_busy = 1'b0;
      got = 0;
      for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
        comp_done = !comp_stall;
        comp_returndata = 32'hA0 + 32'(got);
        res_ready = (cyc >= 10);
        if (res_valid && res_ready) begin
          chk("drain_tag", res_tag, 8'(10 + got));
          chk("drain_data", res_data, 32'hA0 + 32'(got));
          got++;
        end
        step();
      end
      comp_done = 1'b0; res_ready = 1'b0;
      chk("drain_count", 64'(got), 5);
      step();
      chk("drain_jobs_done", jobs_done, 16'd9);
      chk("drain_idle", idle, 1);
    end

    // Result held 20 cycles: stall stays high, next job waits, late done ignored
    push_job(64'hA100, 64'hA200, 64'hA300, 8'h21);
    to_retire(32'h1234_5678, 8'h21, 64'hA100);
    for (int i = 0; i < 20; i++) begin
      comp_done = i[0]; comp_returndata = 32'hDEAD_0000;
      if (i == 0) begin
        job_valid = 1'b1; job_orig = 64'hB100; job_tag = 8'h22;
      end
      step();
      job_valid = 1'b0;
      chk("hold_stall", comp_stall, 1);
      chk("hold_no_launch", comp_start, 0);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, 32'h1234_5678);
      chk("hold_tag", res_tag, 8'h21);
    end
    comp_done = 1'b0;
    retire(16'd10);
    to_retire(32'h55, 8'h22, 64'hB100);
    retire(16'd11);

    // Reset during RUN
    push_job(64'hC100, 64'hC200, 64'hC300, 8'h41);
    push_job(64'hD100, 64'hD200, 64'hD300, 8'h42);
    step();
    chk("prerst_run", comp_stall, 0);
    reset = 1'b1;
    step();
    chk("midrst_start", comp_start, 0);
    chk("midrst_stall", comp_stall, 1);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_jobs_done", jobs_done, 0);
    chk("midrst_idle", idle, 1);
    chk("midrst_ready", job_ready, 1);
    chk("midrst_orig", comp_orig, 0);
    chk("midrst_tag", res_tag, 0);
    reset = 1'b0;
    comp_done = 1'b1; comp_returndata = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late_done_valid", res_valid, 0);
      chk("late_done_start", comp_start, 0);
      chk("late_done_idle", idle, 1);
    end
    comp_done = 1'b0;

`ifdef STENCIL_SEQ_TIMEOUT_EN
    // Watchdog expiry after 50 RUN cycles
    push_job(64'hE100, 64'hE200, 64'hE300, 8'h61);
    step();
    step();
    chk("to_run", comp_stall, 0);
    for (int i = 0; i < 49; i++) step();
    chk("to_not_yet", res_valid, 0);
    step();
    chk("to_valid", res_valid, 1);
    chk("to_status", res_status, 1);
    chk("to_data", res_data, 0);
    chk("to_tag", res_tag, 8'h61);
    chk("to_stall", comp_stall, 1);
    comp_done = 1'b1; comp_returndata = 32'h99;
    step();
    comp_done = 1'b0;
    chk("to_late_status", res_status, 1);
    chk("to_late_data", res_data, 0);
    retire(16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
